// File: rtl/accel_spi_reader_if.sv
// SPI pins plus sample outputs of the ADXL362 reader.
// The reader drives the master side; the sensor and its consumers sit on the slave side.
interface accel_spi_reader_if;
    logic        sclk;
    logic        mosi;
    logic        miso;
    logic        cs_n;
    logic [15:0] ax;
    logic [15:0] ay;
    logic        sample_valid;
    logic        init_done;

    modport master (
        output sclk, mosi, cs_n, ax, ay, sample_valid, init_done,
        input  miso
    );

    modport slave (
        input  sclk, mosi, cs_n, ax, ay, sample_valid, init_done,
        output miso
    );
endinterface

// File: rtl/accel_spi_reader.sv
// ADXL362 SPI master: after the boot delay, writes POWER_CTL to enter measurement mode,
// then periodically burst-reads XDATA/YDATA and presents {ax, ay} with a one-cycle strobe.
module accel_spi_reader #(
    parameter int unsigned SCLK_DIV   = 50,
    parameter int unsigned SAMPLE_DIV = 1000000,
    parameter int unsigned BOOT_DIV   = 500000,
    parameter int unsigned CS_GAP     = 2
) (
    input  logic                clk,
    input  logic                rst,
    accel_spi_reader_if.master  bus
);

    localparam int unsigned GAP_CYC   = CS_GAP * SCLK_DIV;
    localparam int unsigned WAIT_MAX  = (BOOT_DIV > GAP_CYC) ? BOOT_DIV : GAP_CYC;
    localparam int unsigned WAIT_W    = $clog2(WAIT_MAX + 1);
    localparam int unsigned DIV_W     = $clog2(SCLK_DIV + 1);
    localparam int unsigned TMR_W     = $clog2(SAMPLE_DIV + 1);
    localparam int unsigned CFG_BITS  = 24;
    localparam int unsigned READ_BITS = 48;
    localparam logic [47:0] CFG_FRAME  = {8'h0A, 8'h2D, 8'h02, 24'h0};
    localparam logic [47:0] READ_FRAME = {8'h0B, 8'h0E, 32'h0};

    typedef enum logic [2:0] {BOOT, CFG, GAP1, IDLE, READ, GAP} state_t;

    state_t             state;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [DIV_W-1:0]   div_cnt;
    logic [5:0]         bit_cnt;
    logic [47:0]        tx_sr;
    logic [31:0]        rx_sr;
    logic               sclk_q;
    logic               cs_q;
    logic [15:0]        ax_q;
    logic [15:0]        ay_q;
    logic               valid_q;
    logic               init_q;
    logic               cap_pend;
    logic               tick_pend;
    logic               tmr_en;
    logic [TMR_W-1:0]   tmr;

    logic               tick;
    logic               half_tick;
    logic               gap_end;
    logic               go_cfg;
    logic               go_read;
    logic [5:0]         nbits;

    assign tick      = tmr_en && (tmr == TMR_W'(SAMPLE_DIV - 1));
    assign half_tick = (div_cnt == DIV_W'(SCLK_DIV - 1));
    assign gap_end   = (wait_cnt == WAIT_W'(GAP_CYC - 1));
    assign nbits     = (state == CFG) ? 6'(CFG_BITS) : 6'(READ_BITS);
    assign go_cfg    = (state == BOOT) && (wait_cnt == WAIT_W'(BOOT_DIV - 1));
    // A pending or fresh tick launches the read directly out of the gap, so no tick waits an extra cycle
    assign go_read   = (tick || tick_pend) && ((state == IDLE) || ((state == GAP) && gap_end));

    assign bus.sclk         = sclk_q;
    assign bus.mosi         = tx_sr[47];
    assign bus.cs_n         = cs_q;
    assign bus.ax           = ax_q;
    assign bus.ay           = ay_q;
    assign bus.sample_valid = valid_q;
    assign bus.init_done    = init_q;

    // Sequencer and SPI bit engine
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= BOOT;
            wait_cnt  <= '0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b1;
            ax_q      <= '0;
            ay_q      <= '0;
            valid_q   <= 1'b0;
            init_q    <= 1'b0;
            cap_pend  <= 1'b0;
            tick_pend <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (cap_pend) begin
                ax_q     <= {rx_sr[23:16], rx_sr[31:24]};
                ay_q     <= {rx_sr[7:0],   rx_sr[15:8]};
                valid_q  <= 1'b1;
                cap_pend <= 1'b0;
            end

            if (go_read)
                tick_pend <= 1'b0;
            else if (tick && state != IDLE)
                tick_pend <= 1'b1;

            case (state)
                BOOT: wait_cnt <= wait_cnt + WAIT_W'(1);
                CFG, READ: begin
                    div_cnt <= half_tick ? '0 : div_cnt + DIV_W'(1);
                    if (half_tick) begin
                        if (sclk_q) begin
                            sclk_q <= 1'b0;
                            tx_sr  <= {tx_sr[46:0], 1'b0};
                        end else if (bit_cnt != nbits) begin
                            sclk_q  <= 1'b1;
                            rx_sr   <= {rx_sr[30:0], bus.miso};
                            bit_cnt <= bit_cnt + 6'd1;
                            if (state == READ && bit_cnt == nbits - 6'd1)
                                cap_pend <= 1'b1;
                        end else begin
                            cs_q     <= 1'b1;
                            wait_cnt <= '0;
                            state    <= (state == CFG) ? GAP1 : GAP;
                        end
                    end
                end
                GAP1: begin
                    if (gap_end) begin
                        init_q <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                GAP: begin
                    if (!gap_end)
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    else if (!go_read)
                        state <= IDLE;
                end
                default: ;
            endcase

            if (go_cfg || go_read) begin
                cs_q    <= 1'b0;
                sclk_q  <= 1'b0;
                div_cnt <= '0;
                bit_cnt <= '0;
                tx_sr   <= go_cfg ? CFG_FRAME : READ_FRAME;
                state   <= go_cfg ? CFG : READ;
            end
        end
    end

    // Sample timer free-runs from the cycle init_done rises
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr_en <= 1'b0;
            tmr    <= '0;
        end else if (state == GAP1 && gap_end) begin
            tmr_en <= 1'b1;
            tmr    <= '0;
        end else if (tmr_en) begin
            tmr <= tick ? '0 : tmr + TMR_W'(1);
        end
    end

endmodule
